// File: rtl/alarm_timer_ctrl.sv
// Interval timer and time-parameter store for the anti-theft alarm FSM.
// Optional display output remaining_s is enabled by defining TIMER_REMAINING_EN.
module alarm_timer_ctrl #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter logic [3:0]  T_ARM_DEF   = 4'd6,
  parameter logic [3:0]  T_DRV_DEF   = 4'd8,
  parameter logic [3:0]  T_PAS_DEF   = 4'd15,
  parameter logic [3:0]  T_ALARM_DEF = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic       busy
`ifdef TIMER_REMAINING_EN
  ,
  output logic [3:0] remaining_s
`endif
);

  localparam logic [31:0] TERM = 32'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, EXPIRE} state_t;

  state_t      state, state_next;
  logic [3:0]  params [4];
  logic [1:0]  interval_q;
  logic [3:0]  remaining, remaining_next;
  logic [31:0] count, count_next;

  // Divider: a start realigns the second boundary to the start cycle.
  always_comb begin
    count_next = count + 32'd1;
    if (start_timer || count == TERM)
      count_next = 32'd0;
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (start_timer)
          state_next = LOAD;
      end
      LOAD: begin
        remaining_next = (params[interval_q] == 4'd0) ? 4'd1 : params[interval_q];
        state_next     = start_timer ? LOAD : COUNT;
      end
      COUNT: begin
        if (start_timer) begin
          state_next = LOAD;
        end else if (one_hz_enable) begin
          if (remaining <= 4'd1) begin
            state_next     = EXPIRE;
            remaining_next = 4'd0;
          end else begin
            remaining_next = remaining - 4'd1;
          end
        end
      end
      EXPIRE: begin
        state_next = start_timer ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 32'd0;
      remaining     <= 4'd0;
      one_hz_enable <= 1'b0;
      expired       <= 1'b0;
      busy          <= 1'b0;
      params[0]     <= T_ARM_DEF;
      params[1]     <= T_DRV_DEF;
      params[2]     <= T_PAS_DEF;
      params[3]     <= T_ALARM_DEF;
    end else begin
      state         <= state_next;
      count         <= count_next;
      remaining     <= remaining_next;
      one_hz_enable <= (count_next == TERM);
      expired       <= (state_next == EXPIRE);
      busy          <= (state_next == LOAD) || (state_next == COUNT);
      if (reprogram)
        params[time_param_sel] <= time_value;
    end
  end

  always_ff @(posedge clock) begin
    if (start_timer)
      interval_q <= interval;
  end

`ifdef TIMER_REMAINING_EN
  // remaining is cleared on entry to EXPIRE and by reset, so it reads 0 when idle.
  assign remaining_s = remaining;
`endif

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Scoreboard bench for alarm_timer_ctrl with CLK_HZ = 10.
module tb_alarm_timer_ctrl;

  localparam int HZ = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int exp_tick = 0;

  alarm_timer_ctrl #(.CLK_HZ(HZ)) dut (
    .clock(clock),
    .reset(reset),
    .start_timer(start_timer),
    .interval(interval),
    .reprogram(reprogram),
    .time_param_sel(time_param_sel),
    .time_value(time_value),
    .expired(expired),
    .one_hz_enable(one_hz_enable),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: tick period tracking and expired-pulse scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      exp_tick = cyc + HZ;
    end else begin
      if (one_hz_enable) begin
        total++;
        if (cyc != exp_tick) begin
          bad++;
          $display("FAIL tick_cycle actual=%0d required=%0d", cyc, exp_tick);
        end
      end else if (cyc == exp_tick) begin
        total++;
        bad++;
        $display("FAIL tick_missing actual=none required=%0d", exp_tick);
      end
      if (start_timer || one_hz_enable)
        exp_tick = cyc + HZ;
      else if (cyc >= exp_tick)
        exp_tick = exp_tick + HZ;

      if (expired) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL expired_unexpected actual=%0d required=none", cyc);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (cyc != e) begin
            bad++;
            $display("FAIL expired_cycle actual=%0d required=%0d", cyc, e);
          end
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0]) begin
        int e;
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL expired_missing actual=none required=%0d", e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    @(negedge clock);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_busy(input string name, input logic req);
    @(negedge clock);
    total++;
    if (busy !== req) begin
      bad++;
      $display("FAIL %s actual=%0b required=%0b", name, busy, req);
    end
  endtask

  // Called just after a rising edge; expected expiry is S + 1 + N*HZ.
  task automatic start(input logic [1:0] iv, input int n, input bit completes);
    start_timer = 1'b1;
    interval    = iv;
    if (completes)
      exp_q.push_back(cyc + 1 + n * HZ);
    idle(1);
    start_timer = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    reprogram      = 1'b1;
    time_param_sel = sel;
    time_value     = val;
    idle(1);
    reprogram      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_timer = 1'b0; interval = 2'b00;
    reprogram = 1'b0; time_param_sel = 2'b00; time_value = 4'd0;
    idle(3);
    reset = 1'b0;

    @(negedge clock);
    total++;
    if (busy !== 1'b0 || expired !== 1'b0 || one_hz_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs actual=%0b%0b%0b required=000", busy, expired, one_hz_enable);
    end
    idle(25);
    check_busy("idle_busy", 1'b0);
    idle(1);

    // Driver-door default 8 s.
    start(2'b01, 8, 1);
    check_busy("load_busy", 1'b1);
    idle(40);
    check_busy("count_busy", 1'b1);
    idle(45);
    check_busy("post_expire_busy", 1'b0);
    idle(1);

    // Reprogrammed siren duration.
    prog(2'b11, 4'd3);
    start(2'b11, 3, 1);
    idle(35);

    // Write to arm parameter during LOAD: load takes old value 6.
    start(2'b00, 6, 1);
    prog(2'b00, 4'd0);
    idle(64);
    // Arm parameter now 0: minimum 1 s.
    start(2'b00, 1, 1);
    idle(14);

    // Restart at tick 5 of a 15 s countdown.
    prog(2'b00, 4'd6);
    start(2'b10, 15, 0);
    idle(49);
    check("restart_tick_aligned", int'(one_hz_enable), 1);
    idle(0);
    start_timer = 1'b1;
    interval    = 2'b00;
    exp_q.push_back(cyc + 1 + 6 * HZ);
    idle(1);
    start_timer = 1'b0;
    idle(65);

    // Reset at tick 3 of an 8 s countdown.
    start(2'b01, 8, 0);
    idle(29);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_busy("busy_after_reset", 1'b0);
    idle(1);
    // Siren parameter back to default 10.
    start(2'b11, 10, 1);
    idle(105);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
